mipi_rgb888_unpack: RTL and testbench
=====================================

MIPI_RGB888_UNPACK -- requirements
Module: mipi_rgb888_unpack

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 11'd1080, pixels per line; must be a multiple of 4.
REQ-002 SHALL have parameter V_ACTIVE, default 11'd1920, lines per frame.
REQ-003 SHALL have port CLKn, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port RSTn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, payload word strobe from the FIFO write side (fifo_writeen).
REQ-006 SHALL have port in_data, input, 32, payload word; byte0 = [7:0] arrives first on the wire.
REQ-007 SHALL have port frame_start, input, 1, level; high while a frame is active.
REQ-008 SHALL have port out_valid, output, 1, pixel output qualifier.
REQ-009 SHALL have port out_num, output, 1, 0 = one pixel (lane0 only), 1 = two pixels (lane0 then lane1).
REQ-010 SHALL have ports out_pix0 and out_pix1, output, 24 each, pixels as {R,G,B} = {byte2,byte1,byte0} of the pixel's 3-byte group.
REQ-011 SHALL have port out_sof, output, 1, lane0 is pixel (0,0) of the frame.
REQ-012 SHALL have port out_eol, output, 1, the last valid lane carries the last pixel of the line.
REQ-013 SHALL have port out_line, output, 11, line index of the current output.
REQ-014 SHALL have ports frame_done, err_short_line and err_extra_line, output, 1 each, single-cycle pulses.

Function
REQ-015 SHALL accept a word only when in_valid=1 and frame_start=1; otherwise the word is dropped silently.
REQ-016 SHALL repack bytes with a 3-phase gearbox; the phase advances per accepted word.
REQ-017 Phase 0: emit {b2,b1,b0}; keep b3 as residue.
REQ-018 Phase 1: emit {b1,b0,r3}; keep b3,b2.
REQ-019 Phase 2: emit pix0 = {b0,r3,r2} and pix1 = {b3,b2,b1}, out_num=1; clear the residue.
REQ-020 SHALL register all outputs, with a latency of exactly 1 cycle from the accepted word to out_valid.
REQ-021 SHALL count accepted words per line up to WPL = H_ACTIVE*3/4 (810 at default).
REQ-022 At word WPL-1: SHALL assert out_eol, reset the phase to 0 and the word count to 0, and increment the line count.
REQ-023 SHALL detect the frame_start rising edge.
REQ-024 On a frame_start rising edge, SHALL clear the line count, word count and phase, and arm sof.
REQ-025 A word accepted in the same cycle as the rising edge SHALL be treated as word 0 of line 0.
REQ-026 SHALL assert out_sof on the first output after the rising edge only.
REQ-027 SHALL pulse frame_done with the out_eol of line V_ACTIVE-1.
REQ-028 Lines >= V_ACTIVE: SHALL drop words (no out_valid) and pulse err_extra_line once per dropped word.
REQ-029 frame_start falling with word count != 0: SHALL pulse err_short_line, discard the residue, and reset phase, word count and line count.
REQ-030 frame_start falling with word count == 0: SHALL produce no error.
REQ-031 Output fields SHALL be don't-care when out_valid=0; out_sof, out_eol and frame_done SHALL be 0 when out_valid=0.
REQ-032 SHALL size the line counter at 11 bits; the word counter SHALL have no wrap-around beyond WPL-1.

Reset
REQ-033 While RSTn=0, all outputs, counters, phase, residue and edge-detect registers SHALL be 0 asynchronously.
REQ-034 After RSTn deasserts with frame_start already high, SHALL wait for a rising edge before accepting words (edge-detect register reset to 1 is not allowed; no sof without an edge).
REQ-035 Reset asserted mid-line SHALL discard the partial line with no error pulse.

Verification
REQ-036 Line 0: rise frame_start, then words 0x03020100, 0x07060504, 0x0B0A0908 -> outputs 0x020100 (sof=1); 0x050403; then 0x080706 and 0x0B0A09 with out_num=1.
REQ-037 Full frame at H_ACTIVE=8, V_ACTIVE=2: 6 words/line -> out_eol on words 5 and 11, frame_done with the second eol, out_line 0 then 1.
REQ-038 Extra line: send a 3rd line at V_ACTIVE=2 -> no out_valid, 6 err_extra_line pulses.
REQ-039 Short line: drop frame_start after 4 words -> one err_short_line; the next frame restarts at phase 0 with sof.
REQ-040 Gaps and gating: in_valid idle cycles between words -> identical pixel sequence; words with frame_start=0 -> no output.
REQ-041 Async reset mid-line -> outputs 0 immediately; the next frame decodes correctly from word 0.

Source files
------------

// File: rtl/mipi_rgb888_unpack.sv
`default_nettype none
// mipi_rgb888_unpack: 3-phase gearbox that turns 32-bit MIPI payload words into RGB888
// pixels, with line/frame tracking and short-line / extra-line error pulses.
module mipi_rgb888_unpack #(
    parameter logic [10:0] H_ACTIVE = 11'd1080,
    parameter logic [10:0] V_ACTIVE = 11'd1920
) (
    input  logic        CLKn,
    input  logic        RSTn,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        frame_start,
    output logic        out_valid,
    output logic        out_num,
    output logic [23:0] out_pix0,
    output logic [23:0] out_pix1,
    output logic        out_sof,
    output logic        out_eol,
    output logic [10:0] out_line,
    output logic        frame_done,
    output logic        err_short_line,
    output logic        err_extra_line
);
    localparam int              WPL       = int'(H_ACTIVE) * 3 / 4;
    localparam int              WC_W      = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [WC_W-1:0] WC_LAST   = WC_W'(WPL - 1);
    localparam logic [10:0]     LINE_LAST = V_ACTIVE - 11'd1;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_t;

    phase_t          phase, phase_n, ph_e;
    logic [WC_W-1:0] word_cnt, wc_n, wc_e;
    logic [10:0]     line_cnt, line_n, line_e;
    logic [7:0]      res_hi, res_hi_n, res_lo, res_lo_n;
    logic            sof_arm, sof_n, sof_e;
    logic            active, active_n;
    logic            fs_was_low;
    logic            rise, fall, accept, in_range, last;

    logic            valid_n, num_n, sof_o_n, eol_n, done_n, short_n, extra_n;
    logic [23:0]     pix0_n, pix1_n;
    logic [10:0]     line_o_n;

    always_comb begin
        // fs_was_low resets to 0, so a frame_start already high at reset release is not an edge
        rise     = frame_start & fs_was_low;
        fall     = ~frame_start & ~fs_was_low;
        ph_e     = rise ? PH0 : phase;
        wc_e     = rise ? '0 : word_cnt;
        line_e   = rise ? 11'd0 : line_cnt;
        sof_e    = rise | sof_arm;
        accept   = in_valid & frame_start & (rise | active);
        in_range = line_e < V_ACTIVE;
        last     = (wc_e == WC_LAST);

        phase_n  = ph_e;
        wc_n     = wc_e;
        line_n   = line_e;
        sof_n    = sof_e;
        res_hi_n = res_hi;
        res_lo_n = res_lo;
        active_n = frame_start & (rise | active);

        valid_n  = 1'b0;
        num_n    = 1'b0;
        pix0_n   = out_pix0;
        pix1_n   = out_pix1;
        sof_o_n  = 1'b0;
        eol_n    = 1'b0;
        line_o_n = out_line;
        done_n   = 1'b0;
        short_n  = 1'b0;
        extra_n  = 1'b0;

        if (fall) begin
            short_n  = (word_cnt != '0);
            phase_n  = PH0;
            wc_n     = '0;
            line_n   = 11'd0;
            res_hi_n = 8'd0;
            res_lo_n = 8'd0;
            sof_n    = 1'b0;
        end else if (accept && !in_range) begin
            extra_n = 1'b1;
        end else if (accept) begin
            valid_n  = 1'b1;
            sof_o_n  = sof_e;
            sof_n    = 1'b0;
            line_o_n = line_e;
            case (ph_e)
                PH1: begin
                    pix0_n   = {in_data[15:0], res_hi};
                    res_hi_n = in_data[31:24];
                    res_lo_n = in_data[23:16];
                    phase_n  = PH2;
                end
                PH2: begin
                    pix0_n   = {in_data[7:0], res_hi, res_lo};
                    pix1_n   = in_data[31:8];
                    num_n    = 1'b1;
                    res_hi_n = 8'd0;
                    res_lo_n = 8'd0;
                    phase_n  = PH0;
                end
                default: begin
                    pix0_n   = in_data[23:0];
                    res_hi_n = in_data[31:24];
                    phase_n  = PH1;
                end
            endcase
            if (last) begin
                eol_n   = 1'b1;
                done_n  = (line_e == LINE_LAST);
                wc_n    = '0;
                phase_n = PH0;
                line_n  = line_e + 11'd1;
            end else begin
                wc_n = wc_e + 1'b1;
            end
        end
    end

    always_ff @(posedge CLKn or negedge RSTn) begin
        if (!RSTn) begin
            phase          <= PH0;
            word_cnt       <= '0;
            line_cnt       <= 11'd0;
            res_hi         <= 8'd0;
            res_lo         <= 8'd0;
            sof_arm        <= 1'b0;
            active         <= 1'b0;
            fs_was_low     <= 1'b0;
            out_valid      <= 1'b0;
            out_num        <= 1'b0;
            out_pix0       <= 24'd0;
            out_pix1       <= 24'd0;
            out_sof        <= 1'b0;
            out_eol        <= 1'b0;
            out_line       <= 11'd0;
            frame_done     <= 1'b0;
            err_short_line <= 1'b0;
            err_extra_line <= 1'b0;
        end else begin
            phase          <= phase_n;
            word_cnt       <= wc_n;
            line_cnt       <= line_n;
            res_hi         <= res_hi_n;
            res_lo         <= res_lo_n;
            sof_arm        <= sof_n;
            active         <= active_n;
            fs_was_low     <= ~frame_start;
            out_valid      <= valid_n;
            out_num        <= num_n;
            out_pix0       <= pix0_n;
            out_pix1       <= pix1_n;
            out_sof        <= sof_o_n;
            out_eol        <= eol_n;
            out_line       <= line_o_n;
            frame_done     <= done_n;
            err_short_line <= short_n;
            err_extra_line <= extra_n;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mipi_rgb888_unpack.sv
`default_nettype none
// tb_mipi_rgb888_unpack: directed checks of the RGB888 gearbox at H_ACTIVE=8, V_ACTIVE=2.
`timescale 1ns/1ps
module tb_mipi_rgb888_unpack;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        frame_start;
    logic        out_valid, out_num, out_sof, out_eol, frame_done;
    logic        err_short_line, err_extra_line;
    logic [23:0] out_pix0, out_pix1;
    logic [10:0] out_line;

    int checks = 0;
    int errors = 0;

    mipi_rgb888_unpack #(.H_ACTIVE(11'd8), .V_ACTIVE(11'd2)) dut (
        .CLKn(clk), .RSTn(rst_n), .in_valid(in_valid), .in_data(in_data),
        .frame_start(frame_start), .out_valid(out_valid), .out_num(out_num),
        .out_pix0(out_pix0), .out_pix1(out_pix1), .out_sof(out_sof), .out_eol(out_eol),
        .out_line(out_line), .frame_done(frame_done), .err_short_line(err_short_line),
        .err_extra_line(err_extra_line)
    );

    always #5 clk = ~clk;

    // One clock cycle: inputs driven at the falling edge, outputs sampled just after the rising edge.
    task automatic step(input logic v, input logic [31:0] d, input logic fs);
        @(negedge clk);
        in_valid    = v;
        in_data     = d;
        frame_start = fs;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_at(input logic [7:0] base, input int k);
        logic [7:0] b;
        b = base + 8'(4 * k);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    function automatic logic [23:0] pix_at(input logic [7:0] s);
        return {s + 8'd2, s + 8'd1, s};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; frame_start = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_sof, out_eol, frame_done, err_short_line, err_extra_line, out_num} !== 7'd0)
            begin errors++; $display("FAIL reset_flags got %b want 0", {out_valid, out_sof, out_eol, frame_done, err_short_line, err_extra_line, out_num}); end
        checks++;
        if (out_pix0 !== 24'd0 || out_line !== 11'd0)
            begin errors++; $display("FAIL reset_data pix0=%h line=%0d want 0", out_pix0, out_line); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, word_at(8'h00, i), 1'b1);
            checks++;
            if (out_valid !== 1'b0 || out_sof !== 1'b0)
                begin errors++; $display("FAIL no_edge_after_reset w%0d valid=%b sof=%b want 0", i, out_valid, out_sof); end
        end
    endtask

    task automatic test_line0();
        step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h03020100, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_pix0 !== 24'h020100 || out_sof !== 1'b1 || out_num !== 1'b0 || out_line !== 11'd0)
            begin errors++; $display("FAIL line0_w0 v=%b pix0=%h sof=%b num=%b line=%0d want 1 020100 1 0 0", out_valid, out_pix0, out_sof, out_num, out_line); end
        step(1'b1, 32'h07060504, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_pix0 !== 24'h050403 || out_sof !== 1'b0 || out_num !== 1'b0)
            begin errors++; $display("FAIL line0_w1 v=%b pix0=%h sof=%b num=%b want 1 050403 0 0", out_valid, out_pix0, out_sof, out_num); end
        step(1'b1, 32'h0B0A0908, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_pix0 !== 24'h080706 || out_pix1 !== 24'h0B0A09 || out_num !== 1'b1)
            begin errors++; $display("FAIL line0_w2 v=%b pix0=%h pix1=%h num=%b want 1 080706 0B0A09 1", out_valid, out_pix0, out_pix1, out_num); end
        for (int k = 3; k < 6; k++) begin
            step(1'b1, word_at(8'h00, k), 1'b1);
            checks++;
            if (out_eol !== (k == 5) || out_valid !== 1'b1)
                begin errors++; $display("FAIL line0_eol w%0d eol=%b v=%b want %b 1", k, out_eol, out_valid, (k == 5)); end
        end
    endtask

    task automatic test_full_frame();
        step(1'b0, 32'h0, 1'b0);
        checks++;
        if (err_short_line !== 1'b0)
            begin errors++; $display("FAIL fall_at_line_end err_short=%b want 0", err_short_line); end
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            int ln, kk, ph;
            logic [7:0] base, s;
            ln = k / 6; kk = k % 6; ph = kk % 3;
            base = 8'(ln * 64);
            s = base + 8'(4 * kk - ph);
            step(1'b1, word_at(base, kk), 1'b1);
            checks++;
            if (out_valid !== 1'b1 || out_pix0 !== pix_at(s))
                begin errors++; $display("FAIL frame_pix0 w%0d v=%b pix0=%h want 1 %h", k, out_valid, out_pix0, pix_at(s)); end
            checks++;
            if (out_num !== (ph == 2) || (ph == 2 && out_pix1 !== pix_at(s + 8'd3)))
                begin errors++; $display("FAIL frame_pix1 w%0d num=%b pix1=%h want %b %h", k, out_num, out_pix1, (ph == 2), pix_at(s + 8'd3)); end
            checks++;
            if (out_eol !== (kk == 5) || frame_done !== (k == 11) || out_sof !== (k == 0) || out_line !== 11'(ln))
                begin errors++; $display("FAIL frame_ctl w%0d eol=%b done=%b sof=%b line=%0d want %b %b %b %0d", k, out_eol, frame_done, out_sof, out_line, (kk == 5), (k == 11), (k == 0), ln); end
        end
    endtask

    task automatic test_extra_line();
        int pulses;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, word_at(8'h80, k), 1'b1);
            if (err_extra_line === 1'b1) pulses++;
            checks++;
            if (out_valid !== 1'b0 || frame_done !== 1'b0)
                begin errors++; $display("FAIL extra_no_output w%0d v=%b done=%b want 0 0", k, out_valid, frame_done); end
        end
        step(1'b0, 32'h0, 1'b1);
        if (err_extra_line === 1'b1) pulses++;
        checks++;
        if (pulses != 6)
            begin errors++; $display("FAIL extra_pulses got %0d want 6", pulses); end
    endtask

    task automatic test_short_line();
        int pulses;
        pulses = 0;
        step(1'b0, 32'h0, 1'b0);
        checks++;
        if (err_short_line !== 1'b0)
            begin errors++; $display("FAIL short_clean_fall err=%b want 0", err_short_line); end
        step(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, word_at(8'h00, k), 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0);
            if (err_short_line === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1)
            begin errors++; $display("FAIL short_pulses got %0d want 1", pulses); end
        step(1'b1, 32'h03020100, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sof !== 1'b1 || out_pix0 !== 24'h020100 || out_line !== 11'd0 || out_num !== 1'b0)
            begin errors++; $display("FAIL short_restart v=%b sof=%b pix0=%h line=%0d num=%b want 1 1 020100 0 0", out_valid, out_sof, out_pix0, out_line, out_num); end
    endtask

    task automatic test_gaps_gating();
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            int ph;
            logic [7:0] s;
            ph = k % 3;
            s = 8'(4 * k - ph);
            step(1'b1, word_at(8'h00, k), 1'b1);
            checks++;
            if (out_valid !== 1'b1 || out_pix0 !== pix_at(s) || out_num !== (ph == 2) || out_eol !== (k == 5))
                begin errors++; $display("FAIL gaps_word w%0d v=%b pix0=%h num=%b eol=%b want 1 %h %b %b", k, out_valid, out_pix0, out_num, out_eol, pix_at(s), (ph == 2), (k == 5)); end
            if (ph == 2) begin
                checks++;
                if (out_pix1 !== pix_at(s + 8'd3))
                    begin errors++; $display("FAIL gaps_pix1 w%0d pix1=%h want %h", k, out_pix1, pix_at(s + 8'd3)); end
            end
            repeat (k % 2 + 1) begin
                step(1'b0, 32'hDEADBEEF, 1'b1);
                checks++;
                if (out_valid !== 1'b0)
                    begin errors++; $display("FAIL gaps_idle w%0d v=%b want 0", k, out_valid); end
            end
        end
        step(1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, word_at(8'h00, k), 1'b0);
            checks++;
            if (out_valid !== 1'b0 || err_short_line !== 1'b0 || err_extra_line !== 1'b0)
                begin errors++; $display("FAIL gated_word w%0d v=%b short=%b extra=%b want 0 0 0", k, out_valid, err_short_line, err_extra_line); end
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 32'h0, 1'b0);
        step(1'b1, word_at(8'h00, 0), 1'b1);
        step(1'b1, word_at(8'h00, 1), 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_pix0 !== 24'h050403)
            begin errors++; $display("FAIL pre_reset v=%b pix0=%h want 1 050403", out_valid, out_pix0); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pix0 !== 24'd0 || out_sof !== 1'b0)
            begin errors++; $display("FAIL async_reset v=%b pix0=%h sof=%b want 0 000000 0", out_valid, out_pix0, out_sof); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, word_at(8'h00, 2), 1'b1);
        checks++;
        if (out_valid !== 1'b0)
            begin errors++; $display("FAIL post_reset_no_edge v=%b want 0", out_valid); end
        step(1'b0, 32'h0, 1'b0);
        checks++;
        if (err_short_line !== 1'b0)
            begin errors++; $display("FAIL post_reset_short err=%b want 0", err_short_line); end
        step(1'b1, 32'h03020100, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sof !== 1'b1 || out_pix0 !== 24'h020100)
            begin errors++; $display("FAIL post_reset_w0 v=%b sof=%b pix0=%h want 1 1 020100", out_valid, out_sof, out_pix0); end
        step(1'b1, 32'h07060504, 1'b1);
        step(1'b1, 32'h0B0A0908, 1'b1);
        checks++;
        if (out_pix0 !== 24'h080706 || out_pix1 !== 24'h0B0A09 || out_num !== 1'b1)
            begin errors++; $display("FAIL post_reset_w2 pix0=%h pix1=%h num=%b want 080706 0B0A09 1", out_pix0, out_pix1, out_num); end
    endtask

    initial begin
        test_reset();
        test_line0();
        test_full_frame();
        test_extra_line();
        test_short_line();
        test_gaps_gating();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
